neureka_streamout_serializer: RTL and testbench

Masked, multi-beat serializer that merges the per-PE streamout streams of the accumulator array into the single store stream. Inactive PEs are skipped and each active PE contributes a runtime-programmable number of beats. It replaces the plain round-robin serializer in the streamout path of the engine and supports partial output tiles without dummy beats. Data is forwarded combinationally; the block adds zero latency and provides a transfer-complete handshake to the controller.

---
 rtl/neureka_streamout_serializer_pkg.sv | 34 +++
 rtl/neureka_lzc_next.sv | 25 ++
 rtl/neureka_streamout_serializer.sv | 152 +++++++++++++++
 tb/tb_neureka_streamout_serializer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neureka_streamout_serializer_pkg.sv
// Shared types for the streamout serializer: control/flag structs, FSM states and default sizes.
// Sizes follow the default PE array geometry and memory bandwidth of the engine.
package neureka_streamout_serializer_pkg;

  localparam int unsigned NEUREKA_PE_H_DEFAULT  = 3;
  localparam int unsigned NEUREKA_PE_W_DEFAULT  = 3;
  localparam int unsigned NEUREKA_MEM_BANDWIDTH = 256;

  localparam int unsigned SER_NR_PE     = NEUREKA_PE_H_DEFAULT * NEUREKA_PE_W_DEFAULT;
  localparam int unsigned SER_DW        = NEUREKA_MEM_BANDWIDTH;
  localparam int unsigned SER_MAX_BEATS = 8;
  localparam int unsigned SER_CNT_W     = $clog2(SER_MAX_BEATS + 1);
  localparam int unsigned SER_PE_IDX_W  = (SER_NR_PE > 1) ? $clog2(SER_NR_PE) : 1;

  typedef struct packed {
    logic                    start;
    logic [SER_NR_PE-1:0]    pe_mask;
    logic [SER_CNT_W-1:0]    nb_beats;
  } ctrl_streamout_ser_t;

  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic [SER_PE_IDX_W-1:0] cur_pe;
    logic                    last;
  } flags_streamout_ser_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_RUN,
    SER_DONE
  } streamout_ser_state_e;

endpackage

// File: rtl/neureka_lzc_next.sv
// Find-first-set over the remaining PE mask: lowest set index plus an empty flag.
module neureka_lzc_next
  import neureka_streamout_serializer_pkg::*;
#(
  parameter int unsigned NR_PE = SER_NR_PE,
  localparam int unsigned IDX_W = (NR_PE > 1) ? $clog2(NR_PE) : 1
) (
  input  logic [NR_PE-1:0] mask,
  output logic [IDX_W-1:0] idx,
  output logic             empty
);

  // Scan from the top so the lowest set bit wins.
  always_comb begin
    idx   = '0;
    empty = 1'b1;
    for (int i = int'(NR_PE) - 1; i >= 0; i--) begin
      if (mask[i]) begin
        idx   = IDX_W'(i);
        empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/neureka_streamout_serializer.sv
// Masked multi-beat serializer: merges per-PE streamout streams into one store stream.
// Data/valid/ready are forwarded combinationally from the selected PE (zero latency).
module neureka_streamout_serializer
  import neureka_streamout_serializer_pkg::*;
#(
  parameter int unsigned NR_PE     = SER_NR_PE,
  parameter int unsigned DW        = SER_DW,
  parameter int unsigned MAX_BEATS = SER_MAX_BEATS
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clear_i,
  input  logic                           enable_i,
  input  ctrl_streamout_ser_t            ctrl_i,
  input  logic [NR_PE-1:0][DW-1:0]       push_data_i,
  input  logic [NR_PE-1:0][DW/8-1:0]     push_strb_i,
  input  logic [NR_PE-1:0]               push_valid_i,
  output logic [NR_PE-1:0]               push_ready_o,
  output logic [DW-1:0]                  pop_data_o,
  output logic [DW/8-1:0]                pop_strb_o,
  output logic                           pop_valid_o,
  input  logic                           pop_ready_i,
  output flags_streamout_ser_t           flags_o
);

  localparam int unsigned CNT_W = $clog2(MAX_BEATS + 1);
  localparam int unsigned IDX_W = (NR_PE > 1) ? $clog2(NR_PE) : 1;

  streamout_ser_state_e state_reg, state_next;
  logic [NR_PE-1:0]     mask_reg, mask_next;
  logic [CNT_W-1:0]     nb_beats_reg, nb_beats_next;
  logic [CNT_W-1:0]     beat_cnt_reg, beat_cnt_next;
  logic [IDX_W-1:0]     cur_pe_reg, cur_pe_next;

  logic                 run_active;
  logic                 sel_valid;
  logic                 handshake;
  logic                 beat_final;
  logic [NR_PE-1:0]     mask_left;
  logic [NR_PE-1:0]     lzc_mask;
  logic [IDX_W-1:0]     lzc_idx;
  logic                 lzc_empty;
  logic [CNT_W-1:0]     nb_in;
  logic [CNT_W-1:0]     nb_sat;
  logic                 single_left;

  assign run_active = (state_reg == SER_RUN) && enable_i;
  assign sel_valid  = push_valid_i[cur_pe_reg];
  assign handshake  = run_active && sel_valid && pop_ready_i;
  assign beat_final = (beat_cnt_reg == nb_beats_reg - CNT_W'(1));
  assign mask_left  = mask_reg & ~(NR_PE'(1) << cur_pe_reg);
  assign single_left = (mask_reg != '0) && ((mask_reg & (mask_reg - NR_PE'(1))) == '0);

  // One finder serves both the launch (incoming mask) and the PE switch (remaining mask).
  assign lzc_mask = (state_reg == SER_IDLE) ? NR_PE'(ctrl_i.pe_mask) : mask_left;

  neureka_lzc_next #(
    .NR_PE (NR_PE)
  ) i_lzc_next (
    .mask  (lzc_mask),
    .idx   (lzc_idx),
    .empty (lzc_empty)
  );

  // A beat count of 0 means 1; anything past MAX_BEATS saturates.
  always_comb begin
    nb_in  = CNT_W'(ctrl_i.nb_beats);
    nb_sat = nb_in;
    if (nb_in == '0) begin
      nb_sat = CNT_W'(1);
    end else if (nb_in > CNT_W'(MAX_BEATS)) begin
      nb_sat = CNT_W'(MAX_BEATS);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg    <= SER_IDLE;
      mask_reg     <= '0;
      nb_beats_reg <= CNT_W'(1);
      beat_cnt_reg <= '0;
      cur_pe_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      mask_reg     <= mask_next;
      nb_beats_reg <= nb_beats_next;
      beat_cnt_reg <= beat_cnt_next;
      cur_pe_reg   <= cur_pe_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    mask_next     = mask_reg;
    nb_beats_next = nb_beats_reg;
    beat_cnt_next = beat_cnt_reg;
    cur_pe_next   = cur_pe_reg;
    if (clear_i) begin
      state_next    = SER_IDLE;
      mask_next     = '0;
      beat_cnt_next = '0;
      cur_pe_next   = '0;
    end else if (enable_i) begin
      case (state_reg)
        SER_IDLE: begin
          if (ctrl_i.start) begin
            if (lzc_empty) begin
              state_next = SER_DONE;
            end else begin
              state_next    = SER_RUN;
              mask_next     = NR_PE'(ctrl_i.pe_mask);
              nb_beats_next = nb_sat;
              beat_cnt_next = '0;
              cur_pe_next   = lzc_idx;
            end
          end
        end
        SER_RUN: begin
          if (handshake) begin
            if (beat_final) begin
              mask_next     = mask_left;
              beat_cnt_next = '0;
              if (lzc_empty) begin
                state_next = SER_DONE;
              end else begin
                cur_pe_next = lzc_idx;
              end
            end else begin
              beat_cnt_next = beat_cnt_reg + CNT_W'(1);
            end
          end
        end
        SER_DONE: state_next = SER_IDLE;
        default:  state_next = SER_IDLE;
      endcase
    end
  end

  assign pop_data_o  = push_data_i[cur_pe_reg];
  assign pop_strb_o  = push_strb_i[cur_pe_reg];
  assign pop_valid_o = run_active && sel_valid;

  for (genvar gi = 0; gi < NR_PE; gi++) begin : gen_push_ready
    assign push_ready_o[gi] = run_active && pop_ready_i && (cur_pe_reg == IDX_W'(gi));
  end

  assign flags_o.busy   = (state_reg == SER_RUN);
  assign flags_o.done   = (state_reg == SER_DONE) && enable_i;
  assign flags_o.cur_pe = SER_PE_IDX_W'(cur_pe_reg);
  assign flags_o.last   = (state_reg == SER_RUN) && beat_final && single_left;

endmodule

// File: tb/tb_neureka_streamout_serializer.sv
// Directed bench for the streamout serializer with a per-beat scoreboard of expected PE/last.
module tb_neureka_streamout_serializer;
  import neureka_streamout_serializer_pkg::*;

  localparam int NR_PE = 9;
  localparam int DW    = 256;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  typedef struct { int pe; bit last; } exp_t;

  logic                       clk;
  logic                       rst_n;
  logic                       clear;
  logic                       enable;
  ctrl_streamout_ser_t        ctrl;
  logic [NR_PE-1:0][DW-1:0]   push_data;
  logic [NR_PE-1:0][DW/8-1:0] push_strb;
  logic [NR_PE-1:0]           push_valid;
  logic [NR_PE-1:0]           push_ready;
  logic [DW-1:0]              pop_data;
  logic [DW/8-1:0]            pop_strb;
  logic                       pop_valid;
  logic                       pop_ready;
  flags_streamout_ser_t       flags;

  int   checks = 0;
  int   errors = 0;
  int   src_seq [NR_PE];
  int   exp_seq [NR_PE];
  exp_t exp_q [$];
  int   m_state;
  int   cyc;
  int   done_seen;
  int   beats;
  bit   rnd_valid;
  bit   rnd_ready;

  neureka_streamout_serializer dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .enable_i     (enable),
    .ctrl_i       (ctrl),
    .push_data_i  (push_data),
    .push_strb_i  (push_strb),
    .push_valid_i (push_valid),
    .push_ready_o (push_ready),
    .pop_data_o   (pop_data),
    .pop_strb_o   (pop_strb),
    .pop_valid_o  (pop_valid),
    .pop_ready_i  (pop_ready),
    .flags_o      (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat_data(int pe, int seq);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) begin
      d[i*32 +: 32] = 32'(pe * 65536 + seq) ^ (32'h9E3779B9 * 32'(i + 1));
    end
    return d;
  endfunction

  function automatic logic [DW/8-1:0] pat_strb(int pe, int seq);
    return 32'(pe * 4099 + seq * 7) ^ 32'hF0F0_0F0F;
  endfunction

  always_comb begin
    for (int p = 0; p < NR_PE; p++) begin
      push_data[p] = pat_data(p, src_seq[p]);
      push_strb[p] = pat_strb(p, src_seq[p]);
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check outputs at negedge, update model/sources at posedge, re-drive at +1.
  task automatic tick();
    int               fp;
    bit               run;
    bit               hs;
    logic             exp_pv;
    logic [NR_PE-1:0] exp_rdy;
    logic [NR_PE-1:0] rdy_s;
    logic [NR_PE-1:0] consumed;
    int               nbe;
    int               hi;
    @(negedge clk);
    cyc++;
    fp      = (exp_q.size() > 0) ? exp_q[0].pe : 0;
    run     = (m_state == M_RUN);
    exp_pv  = run && enable && push_valid[fp];
    exp_rdy = (run && enable && pop_ready) ? (NR_PE'(1) << fp) : '0;
    hs      = exp_pv && pop_ready;
    chk("busy",       DW'(flags.busy),  DW'(run));
    chk("done",       DW'(flags.done),  DW'(m_state == M_DONE && enable));
    chk("last",       DW'(flags.last),  DW'(run && exp_q.size() > 0 && exp_q[0].last));
    chk("pop_valid",  DW'(pop_valid),   DW'(exp_pv));
    chk("push_ready", DW'(push_ready),  DW'(exp_rdy));
    if (run) chk("cur_pe", DW'(flags.cur_pe), DW'(fp));
    if (hs) begin
      chk("pop_data", pop_data,      pat_data(fp, exp_seq[fp]));
      chk("pop_strb", DW'(pop_strb), DW'(pat_strb(fp, exp_seq[fp])));
      beats++;
    end
    if (flags.done && done_seen < 0) done_seen = cyc;
    rdy_s = push_ready;
    @(posedge clk);
    if (hs) exp_seq[fp]++;
    if (clear) begin
      m_state = M_IDLE;
      exp_q.delete();
    end else if (enable) begin
      case (m_state)
        M_IDLE: if (ctrl.start) begin
          if (ctrl.pe_mask == '0) begin
            m_state = M_DONE;
          end else begin
            nbe = (ctrl.nb_beats == 0) ? 1 : ((ctrl.nb_beats > 8) ? 8 : int'(ctrl.nb_beats));
            hi  = 0;
            for (int p = 0; p < NR_PE; p++) if (ctrl.pe_mask[p]) hi = p;
            for (int p = 0; p < NR_PE; p++) begin
              if (ctrl.pe_mask[p]) begin
                for (int b = 0; b < nbe; b++) exp_q.push_back('{pe: p, last: (p == hi && b == nbe - 1)});
              end
            end
            m_state = M_RUN;
          end
        end
        M_RUN: if (hs) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) m_state = M_DONE;
        end
        default: m_state = M_IDLE;
      endcase
    end
    consumed = rdy_s & push_valid;
    #1;
    for (int p = 0; p < NR_PE; p++) begin
      if (consumed[p]) src_seq[p]++;
      if (!push_valid[p] || consumed[p]) push_valid[p] = rnd_valid ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    pop_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic start_pass(input logic [NR_PE-1:0] mask, input logic [3:0] nb);
    cyc       = -1;
    done_seen = -1;
    beats     = 0;
    ctrl      = '{start: 1'b1, pe_mask: mask, nb_beats: nb};
    tick();
    ctrl.start = 1'b0;
  endtask

  task automatic run_until_idle(input int budget, input int exp_done);
    int n = 0;
    while (m_state != M_IDLE && n < budget) begin
      tick();
      n++;
    end
    chk("pass_timeout", DW'(m_state == M_IDLE), DW'(1));
    if (exp_done >= 0) chk("done_cycle", DW'(done_seen), DW'(exp_done));
  endtask

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    enable     = 1'b1;
    ctrl       = '0;
    push_valid = '1;
    pop_ready  = 1'b1;
    rnd_valid  = 1'b0;
    rnd_ready  = 1'b0;
    m_state    = M_IDLE;
    cyc        = 0;
    done_seen  = -1;
    beats      = 0;
    for (int p = 0; p < NR_PE; p++) begin
      src_seq[p] = 0;
      exp_seq[p] = 0;
    end

    // Reset state with valids and ready asserted on the inputs
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",       DW'(flags.busy),   DW'(0));
    chk("rst_done",       DW'(flags.done),   DW'(0));
    chk("rst_last",       DW'(flags.last),   DW'(0));
    chk("rst_cur_pe",     DW'(flags.cur_pe), DW'(0));
    chk("rst_pop_valid",  DW'(pop_valid),    DW'(0));
    chk("rst_push_ready", DW'(push_ready),   DW'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Full mask, one beat each
    start_pass(9'h1FF, 4'd1);
    run_until_idle(40, 10);

    // Sparse mask, three beats each
    start_pass(9'b100010010, 4'd3);
    run_until_idle(40, 10);

    // nb_beats 0 behaves as 1; nb_beats at maximum on a single PE
    start_pass(9'b000000110, 4'd0);
    run_until_idle(20, 3);
    start_pass(9'h100, 4'd8);
    run_until_idle(30, 9);

    // Empty mask
    start_pass(9'h000, 4'd3);
    run_until_idle(10, 1);
    tick();

    // Clear after 4 beats, then a fresh single-PE pass
    start_pass(9'h1FF, 4'd2);
    for (int n = 0; n < 50 && beats < 4; n++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    chk("clear_done_seen", DW'(done_seen), DW'(-1));
    start_pass(9'h001, 4'd1);
    run_until_idle(20, 2);

    // Start pulse during RUN is ignored; enable low for 5 cycles mid-pass
    start_pass(9'h00F, 4'd2);
    tick();
    ctrl = '{start: 1'b1, pe_mask: 9'h1F0, nb_beats: 4'd5};
    tick();
    ctrl.start = 1'b0;
    tick();
    enable = 1'b0;
    repeat (5) tick();
    enable = 1'b1;
    run_until_idle(40, 14);

    // Random backpressure and valid gaps over several random passes
    rnd_valid = 1'b1;
    rnd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      start_pass(9'($urandom_range(1, 511)), 4'($urandom_range(1, 8)));
      run_until_idle(3000, -1);
    end
    rnd_valid = 1'b0;
    rnd_ready = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
